// File: rtl/alu_iter.sv
// alu_iter: iterative integer ALU.
// Single-cycle logic/arithmetic/shift operations, and multi-cycle
// shift-add multiply and restoring divide with one iteration per clock.
// A request is taken when in_valid && in_ready. Results and flags are held
// until the next out_valid pulse.

module alu_iter #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             N,
    output logic             dz
);

    // The counter has to hold the value WIDTH itself, hence WIDTH+1.
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  ITERS    = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_SLL = 3'b011,
        OP_SRL = 3'b100,
        OP_SRA = 3'b101,
        OP_MUL = 3'b110,
        OP_DIV = 3'b111
    } op_e;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    // Everything that is published on an out_valid pulse.
    typedef struct packed {
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        logic             z;
        logic             c;
        logic             v;
        logic             n;
        logic             dz;
    } res_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state;
    logic [CW-1:0]     cnt;
    logic              is_div_q;   // iterating a divide (else multiply)
    logic              neg_lo_q;   // negate product / quotient at the end
    logic              neg_hi_q;   // negate remainder at the end
    logic              sgn_q;      // signed MUL: overflow test uses sign extension
    logic              ovf_q;      // signed most-negative / -1 divide
    logic [WIDTH-1:0]  dvs_q;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]  hi_q;       // partial product high half / partial remainder
    logic [WIDTH-1:0]  lo_q;       // multiplier bits / dividend bits -> quotient
    res_t              out_q;

    // ------------------------------------------------------------------
    // Request handshake and operand preparation
    // ------------------------------------------------------------------
    logic              accept;
    logic              is_iter;
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic [SHW-1:0]    sh;

    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign is_iter  = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    assign sh       = b[SHW-1:0];

    // The most-negative value maps onto itself, which is its correct
    // magnitude when read as unsigned.
    assign mag_a = (signed_op && a[WIDTH-1]) ? -a : a;
    assign mag_b = (signed_op && b[WIDTH-1]) ? -b : b;

    // ------------------------------------------------------------------
    // Single-cycle operations, computed straight from the request inputs
    // ------------------------------------------------------------------
    res_t              fast;
    logic [WIDTH:0]    fast_sum;
    logic [WIDTH:0]    fast_diff;

    assign fast_sum  = {1'b0, a} + {1'b0, b};
    assign fast_diff = {1'b0, a} - {1'b0, b};

    // Result and flags for the latency-1 operations.
    always_comb begin
        // NOTE: every field gets a default before the case, so no path can leave a value unassigned and infer a latch.
        fast = '0;
        case (op)
            OP_AND: fast.lo = a & b;
            OP_ADD: begin
                fast.lo = fast_sum[WIDTH-1:0];
                fast.c  = fast_sum[WIDTH];
                fast.v  = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (fast_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                fast.lo = fast_diff[WIDTH-1:0];
                fast.c  = fast_diff[WIDTH];
                fast.v  = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (fast_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL: fast.lo = a << sh;
            OP_SRL: fast.lo = a >> sh;
            OP_SRA: fast.lo = $unsigned($signed(a) >>> sh);
            OP_DIV: begin
                // Only reached on this path when b == 0.
                fast.lo = '1;
                fast.hi = a;
                fast.dz = 1'b1;
            end
            default: fast.lo = '0;
        endcase
        fast.z = (fast.lo == '0);
        fast.n = fast.lo[WIDTH-1];
    end

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply or restoring divide
    // ------------------------------------------------------------------
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_diff;
    logic [WIDTH-1:0]  nxt_hi;
    logic [WIDTH-1:0]  nxt_lo;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, dvs_q};

    // Next partial values; a set top bit of div_diff means the trial
    // subtraction went negative and the remainder is restored.
    always_comb begin
        if (is_div_q) begin
            nxt_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            nxt_lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Completion of an iterative operation: sign fix-up and flags
    // ------------------------------------------------------------------
    res_t              fin;
    logic [2*WIDTH-1:0] mag_prod;
    logic [2*WIDTH-1:0] prod;

    assign mag_prod = {nxt_hi, nxt_lo};
    assign prod     = neg_lo_q ? -mag_prod : mag_prod;

    // Signed results are rebuilt from magnitudes after the last iteration.
    always_comb begin
        fin = '0;
        if (is_div_q) begin
            fin.lo = neg_lo_q ? -nxt_lo : nxt_lo;
            fin.hi = neg_hi_q ? -nxt_hi : nxt_hi;
            fin.v  = ovf_q;
        end else begin
            fin.lo = prod[WIDTH-1:0];
            fin.hi = prod[2*WIDTH-1:WIDTH];
            fin.v  = sgn_q ? (fin.hi != {WIDTH{fin.lo[WIDTH-1]}})
                           : (fin.hi != '0);
        end
        fin.z = (fin.lo == '0);
        fin.n = fin.lo[WIDTH-1];
    end

    // ------------------------------------------------------------------
    // Control FSM, iteration registers and registered outputs
    // ------------------------------------------------------------------
    // Accept requests, step the iteration, publish results.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the datapath registers are reset as well, because the outputs have to read zero while reset is held.
            state     <= IDLE;
            cnt       <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            sgn_q     <= 1'b0;
            ovf_q     <= 1'b0;
            dvs_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples the values from before this edge.
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_iter) begin
                            state    <= BUSY;
                            cnt      <= ITERS;
                            is_div_q <= (op == OP_DIV);
                            neg_lo_q <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_hi_q <= signed_op && a[WIDTH-1];
                            sgn_q    <= signed_op;
                            ovf_q    <= signed_op && (op == OP_DIV) &&
                                        (a == MOST_NEG) && (b == '1);
                            dvs_q    <= mag_b;
                            hi_q     <= '0;
                            lo_q     <= mag_a;
                        end else begin
                            out_q     <= fast;
                            out_valid <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    hi_q <= nxt_hi;
                    lo_q <= nxt_lo;
                    cnt  <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state     <= IDLE;
                        out_q     <= fin;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign result    = out_q.lo;
    assign result_hi = out_q.hi;
    assign Z         = out_q.z;
    assign C         = out_q.c;
    assign V         = out_q.v;
    assign N         = out_q.n;
    assign dz        = out_q.dz;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: self-checking bench for alu_iter (WIDTH = 16).
// Expected values come from an integer-arithmetic reference model.

module tb_alu_iter;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic          signed_op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          z, c, v, n, dz;

    int n_total = 0;
    int n_pass  = 0;

    alu_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .result_hi (result_hi),
        .Z         (z),
        .C         (c),
        .V         (v),
        .N         (n),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [4:0]   flags;   // {Z, C, V, N, dz}
        int           lat;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [2:0] o, input logic s,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint ux = x;
        longint uy = y;
        longint sx = $signed(x);
        longint sy = $signed(y);
        longint full;
        longint q;
        longint r;
        logic   zf, cf, vf, df;
        int     amt = int'(y[3:0]);
        e.res = '0; e.hi = '0; e.lat = 1;
        cf = 1'b0; vf = 1'b0; df = 1'b0;
        case (o)
            3'd0: e.res = x & y;
            3'd1: begin
                full  = ux + uy;
                e.res = full[15:0];
                cf    = (full > 65535);
                full  = sx + sy;
                vf    = (full > 32767) || (full < -32768);
            end
            3'd2: begin
                full  = ux - uy;
                e.res = full[15:0];
                cf    = (ux < uy);
                full  = sx - sy;
                vf    = (full > 32767) || (full < -32768);
            end
            3'd3: begin full = ux << amt; e.res = full[15:0]; end
            3'd4: begin full = ux >> amt; e.res = full[15:0]; end
            3'd5: begin full = sx >>> amt; e.res = full[15:0]; end
            3'd6: begin
                e.lat = 17;
                full  = s ? sx * sy : ux * uy;
                e.res = full[15:0];
                e.hi  = full[31:16];
                vf    = s ? ((full > 32767) || (full < -32768)) : (full > 65535);
            end
            default: begin
                if (y == 0) begin
                    e.res = 16'hFFFF;
                    e.hi  = x;
                    df    = 1'b1;
                end else begin
                    e.lat = 17;
                    if (s) begin q = sx / sy; r = sx % sy; end
                    else   begin q = ux / uy; r = ux % uy; end
                    e.res = q[15:0];
                    e.hi  = r[15:0];
                    vf    = s && (q > 32767);
                end
            end
        endcase
        zf = (e.res == 0);
        e.flags = {zf, cf, vf, e.res[15], df};
        return e;
    endfunction

    // Issue one request, wait for its completion, check everything.
    task automatic do_op(input string tag, input logic [2:0] o, input logic s,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   lat;
        int   busy_low;
        e = model(o, s, x, y);
        @(negedge clk);
        check({tag, " in_ready before"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; signed_op = s; a = x; b = y;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom(); b = $urandom(); op = 3'($urandom());
        lat = 1;
        busy_low = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) busy_low++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(e.lat));
        check({tag, " busy cycles"}, 64'(busy_low), 64'(e.lat - 1));
        check({tag, " result"}, 64'(result), 64'(e.res));
        check({tag, " result_hi"}, 64'(result_hi), 64'(e.hi));
        check({tag, " flags ZCVNdz"}, 64'({z, c, v, n, dz}), 64'(e.flags));
        @(negedge clk);
        check({tag, " pulse+hold"}, 64'({out_valid, result, result_hi}), 64'({1'b0, e.res, e.hi}));
    endtask

    initial begin
        exp_t e1;
        exp_t e2;
        int   lat;
        int   seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset = 1'b1; in_valid = 1'b0; op = '0; signed_op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", 64'({out_valid, result, result_hi, z, c, v, n, dz}), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("in_ready after reset", 64'(in_ready), 64'd1);

        // Directed vectors with explicit expectations.
        do_op("add_wrap", 3'd1, 1'b0, 16'hFFFF, 16'h0001);
        check("add_wrap const", 64'({result, z, c, v, n}), 64'({16'h0000, 4'b1100}));
        do_op("sub_ovf", 3'd2, 1'b1, 16'h8000, 16'h0001);
        check("sub_ovf const", 64'({result, c, v, n}), 64'({16'h7FFF, 3'b010}));
        do_op("sra", 3'd5, 1'b0, 16'h8000, 16'd4);
        check("sra const", 64'({result, n}), 64'({16'hF800, 1'b1}));
        do_op("mul_s", 3'd6, 1'b1, 16'hFFFD, 16'h0007);
        check("mul_s const", 64'({result, result_hi, v}), 64'({16'hFFEB, 16'hFFFF, 1'b0}));
        do_op("div_s", 3'd7, 1'b1, 16'hFFF9, 16'h0002);
        check("div_s const", 64'({result, result_hi}), 64'({16'hFFFD, 16'hFFFF}));
        do_op("div_zero", 3'd7, 1'b0, 16'h1234, 16'h0000);
        check("div_zero const", 64'({result, result_hi, dz}), 64'({16'hFFFF, 16'h1234, 1'b1}));
        do_op("div_minneg", 3'd7, 1'b1, 16'h8000, 16'hFFFF);
        check("div_minneg const", 64'({result, result_hi, v, dz}), 64'({16'h8000, 16'h0000, 2'b10}));
        do_op("mul_u_big", 3'd6, 1'b0, 16'hFFFF, 16'hFFFF);
        do_op("sll_15", 3'd3, 1'b0, 16'h0003, 16'd15);

        // Reset in the 5th BUSY cycle of a MUL aborts it.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd6; signed_op = 1'b0; a = 16'h0123; b = 16'h0045;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort outputs", 64'({out_valid, result, result_hi, z, c, v, n, dz}), 64'd0);
        check("abort in_ready low", 64'(in_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort in_ready high", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (24) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("abort no out_valid", 64'(seen), 64'd0);

        // ADD then AND on consecutive cycles.
        e1 = model(3'd1, 1'b0, 16'h1111, 16'h2222);
        e2 = model(3'd0, 1'b0, 16'hF0F0, 16'h3C3C);
        in_valid = 1'b1; op = 3'd1; a = 16'h1111; b = 16'h2222;
        @(negedge clk);
        check("b2b add", 64'({out_valid, result}), 64'({1'b1, e1.res}));
        op = 3'd0; a = 16'hF0F0; b = 16'h3C3C;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b and", 64'({out_valid, result}), 64'({1'b1, e2.res}));
        @(negedge clk);

        // in_valid held through a DIV's BUSY phase.
        e1 = model(3'd7, 1'b0, 16'd1000, 16'd7);
        e2 = model(3'd1, 1'b0, 16'h0005, 16'h0009);
        in_valid = 1'b1; op = 3'd7; signed_op = 1'b0; a = 16'd1000; b = 16'd7;
        @(negedge clk);
        op = 3'd1; a = 16'h0005; b = 16'h0009;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("held div latency", 64'(lat), 64'd17);
        check("held div result", 64'({result, result_hi}), 64'({e1.res, e1.hi}));
        @(negedge clk);
        in_valid = 1'b0;
        check("held add result", 64'({out_valid, result}), 64'({1'b1, e2.res}));
        @(negedge clk);
        check("held add single", 64'(out_valid), 64'd0);

        // Randomized operations, biased toward boundary operands.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 7))
                0: ra = 16'h0000;
                1: ra = 16'h8000;
                2: ra = 16'hFFFF;
                3: ra = 16'h7FFF;
                default: ra = 16'($urandom());
            endcase
            case ($urandom_range(0, 7))
                0: rb = 16'h0000;
                1: rb = 16'hFFFF;
                2: rb = 16'h0001;
                3: rb = 16'h8000;
                default: rb = 16'($urandom());
            endcase
            do_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width in bits (even, >= 8).
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 op  input  3  000 AND, 001 ADD, 010 SUB, 011 SLL, 100 SRL, 101 SRA, 110 MUL, 111 DIV.
REQ-009 signed_op  input  1  two's-complement interpretation for ADD/SUB/MUL/DIV.
REQ-010 a, b  input  WIDTH each  operands.
REQ-011 out_valid  output  1  one-cycle pulse: result and flags valid.
REQ-012 result  output  WIDTH  primary result (MUL low half, DIV quotient).
REQ-013 result_hi  output  WIDTH  MUL high half, DIV remainder, else 0.
REQ-014 Z, C, V, N  output  1 each  zero, carry/borrow, overflow, negative flags.
REQ-015 dz  output  1  divide-by-zero indicator.

Function
REQ-016 Request accepted on rising edge where in_valid && in_ready; a, b, op, signed_op captured then.
REQ-017 FSM states IDLE, BUSY; in_ready = (state == IDLE) && !reset.
REQ-018 AND/ADD/SUB/SLL/SRL/SRA and DIV with b == 0: latency 1, out_valid high the cycle after acceptance, FSM stays IDLE (throughput 1/cycle).
REQ-019 MUL/DIV (b != 0): IDLE -> BUSY, iteration counter loaded with WIDTH, one iteration per cycle; after WIDTH BUSY cycles FSM returns to IDLE with out_valid high that cycle (out_valid at acceptance + WIDTH + 1).
REQ-020 in_valid during BUSY is not accepted and has no effect; a request accepted in the same cycle out_valid is high is legal.
REQ-021 result, result_hi, flags, dz hold their value until the next out_valid; only out_valid pulses.
REQ-022 ADD/SUB: WIDTH-bit wrap result; C = bit WIDTH of the (WIDTH+1)-bit unsigned sum/difference (borrow for SUB); V = two's-complement overflow; identical in both signed_op modes.
REQ-023 SLL/SRL logical, SRA arithmetic (sign bit replicated), amount b[SHW-1:0]; C = V = 0.
REQ-024 MUL: shift-add on magnitudes; signed product negated when operand signs differ; {result_hi, result} = full 2*WIDTH product; V = 1 when result_hi is not the zero (unsigned) / sign (signed) extension of result; C = 0.
REQ-025 DIV: restoring division on magnitudes; signed quotient sign = a sign XOR b sign, remainder sign = a sign (truncate toward zero); C = V = 0.
REQ-026 DIV signed, a = most-negative, b = all-ones: result = most-negative, result_hi = 0, V = 1.
REQ-027 DIV b == 0: result = all-ones, result_hi = a, dz = 1, V = C = 0; dz = 0 for every other completion.
REQ-028 Z = (result == 0), N = result[WIDTH-1] for every op; AND: C = V = 0.

Reset
REQ-029 While reset high: state IDLE, counter 0, out_valid 0, result/result_hi 0, Z C V N dz 0, in_ready 0.
REQ-030 Reset during BUSY aborts the operation; no out_valid is ever produced for it; in_ready = 1 the first cycle after reset deasserts.

Verification
REQ-031 ADD unsigned a=0xFFFF b=0x0001 -> next cycle out_valid=1, result=0x0000, Z=1 C=1 V=0 N=0.
REQ-032 SUB signed a=0x8000 b=0x0001 -> result=0x7FFF, V=1, N=0, C=0; SRA a=0x8000 b=4 -> result=0xF800, N=1.
REQ-033 MUL signed a=0xFFFD b=0x0007 -> in_ready=0 for 16 cycles, out_valid at acceptance+17, result=0xFFEB, result_hi=0xFFFF, V=0.
REQ-034 DIV signed a=0xFFF9 b=0x0002 -> result=0xFFFD, result_hi=0xFFFF at acceptance+17; DIV a=0x1234 b=0 -> next cycle result=0xFFFF, result_hi=0x1234, dz=1.
REQ-035 reset pulsed in 5th BUSY cycle of MUL -> no out_valid, all outputs 0, in_ready=1 one cycle after deassert.
REQ-036 ADD then AND on consecutive cycles -> out_valid on two consecutive cycles with matching results; in_valid held during a DIV's BUSY -> accepted only in the out_valid cycle.
